video_timing_gen: RTL and testbench
===================================

// Module: video_timing_gen
// PURPOSE
//  Parametrised raster timing generator; replaces the fixed 640x480 vga block in labkit top-levels.
//  Produces pixel/line counters, hsync/vsync with selectable polarity, display-enable, frame strobes.
//  Runs on any system clock via pixel clock-enable (e.g. 100 MHz clock, ce 1-in-4 = 25 MHz pixel rate).
//  Sits between the clock generator and pixel-colour logic driving VGA_R/G/B, VGA_HS, VGA_VS.
// PARAMETERS
//  H_ACTIVE   640  visible pixels per line
//  H_FP       16   horizontal front porch, pixels
//  H_SYNC     96   horizontal sync width, pixels
//  H_BP       48   horizontal back porch, pixels
//  V_ACTIVE   480  visible lines per frame
//  V_FP       10   vertical front porch, lines
//  V_SYNC     2    vertical sync width, lines
//  V_BP       33   vertical back porch, lines
//  HSYNC_POL  0    asserted level of hsync (0 = active-low)
//  VSYNC_POL  0    asserted level of vsync (0 = active-low)
//  Derived: H_TOTAL=sum of H_*, V_TOTAL=sum of V_*; HW=$clog2(H_TOTAL), VW=$clog2(V_TOTAL)
// PORTS
//  vga_clock        in   1   system clock, all logic on rising edge
//  reset            in   1   synchronous, active-high
//  pixel_ce         in   1   pixel clock-enable; counters advance only when high
//  line_cmp         in   VW  raster-compare line (used only with VTG_LINE_IRQ_EN)
//  hcount           out  HW  pixel number on current line, 0..H_TOTAL-1
//  vcount           out  VW  line number, 0..V_TOTAL-1
//  hsync            out  1   horizontal sync, level per HSYNC_POL
//  vsync            out  1   vertical sync, level per VSYNC_POL
//  at_display_area  out  1   high iff hcount<H_ACTIVE && vcount<V_ACTIVE
//  start_of_frame   out  1   1-cycle pulse on cycle counters enter (0,0)
//  end_of_line      out  1   1-cycle pulse on cycle hcount enters H_TOTAL-1
//  frame_count      out  16  frames completed, wraps 0xFFFF->0
//  line_irq         out  1   1-cycle raster-compare pulse
// BEHAVIOUR
//  - One clock (vga_clock); reset synchronous active-high, dominates pixel_ce.
//  - Reset values: hcount=0, vcount=0, at_display_area=1, hsync=~HSYNC_POL, vsync=~VSYNC_POL,
//    start_of_frame=0, end_of_line=0, frame_count=0, line_irq=0.
//  - All outputs registered and mutually aligned: sync/enable/strobes describe the (hcount,vcount)
//    shown in the same cycle (computed from next-state counters; zero skew).
//  - On pixel_ce: hcount = (hcount==H_TOTAL-1) ? 0 : hcount+1; vcount advances only on hcount wrap,
//    vcount = (vcount==V_TOTAL-1) ? 0 : vcount+1. pixel_ce low: every output holds, strobes drop to 0.
//  - hsync asserted iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC.
//  - vsync asserted iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (whole lines, switches at hcount=0).
//  - Strobes last exactly one clock even when pixel_ce stays low afterward.
//  - frame_count increments with start_of_frame; not on the reset entry into (0,0).
//  - Reset mid-frame: next edge counters (0,0), no start_of_frame pulse, frame_count=0.
// CONFIGURATION
//  - `VTG_LINE_IRQ_EN defined: line_irq pulses one cycle when counters advance to (0, line_cmp);
//    line_cmp sampled on that advance; line_cmp>=V_TOTAL never fires.
//  - Not defined: line_irq tied 0, line_cmp ignored; port list unchanged.
// STRUCTURE
//  - Package video_timing_pkg: default 640x480@60 timing constants, a timing struct typedef,
//    width helper function, sync polarity constants ACTIVE_LOW/ACTIVE_HIGH.
//  - Sub-module timing_axis_counter (params ACTIVE/FP/SYNC/BP/POL): count, active, sync, wrap;
//    one instance for H (advance=pixel_ce), one for V (advance=pixel_ce & h wrap).
//  - Top: strobes, frame_count, optional raster compare.
// TESTING
//  1. Defaults, pixel_ce=1: hsync low for hcount 656..751 (96 clocks), line period 800 clocks.
//  2. Defaults: vsync low on vcount 490..491 (1600 clocks), frame period 420000 clocks;
//     start_of_frame once per frame; frame_count 0->1->2.
//  3. pixel_ce high 1 of 4 clocks: frame period 1680000 clocks; strobes 1 clock wide; outputs hold.
//  4. reset at (hcount=400,vcount=200): next clock (0,0), at_display_area=1, syncs inactive,
//     frame_count=0, no start_of_frame pulse.
//  5. HSYNC_POL=1, H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3: hsync high only at hcount 18..20, period 24.
//  6. VTG_LINE_IRQ_EN, line_cmp=100: one line_irq per frame at (0,100); line_cmp=600: none;
//     macro undefined: line_irq always 0.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared timing constants, types and helpers for the raster timing generator.
package video_timing_pkg;

  localparam logic ACTIVE_LOW  = 1'b0;
  localparam logic ACTIVE_HIGH = 1'b1;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } axis_timing_t;

  // 640x480 @ 60 Hz, 25 MHz pixel rate
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam axis_timing_t VGA_640X480_H = '{active: 640, fp: 16, sync: 96, bp: 48};
  localparam axis_timing_t VGA_640X480_V = '{active: 480, fp: 10, sync: 2, bp: 33};

  // Counter width for an axis of 'total' positions; never narrower than one bit.
  function automatic int axis_width(input int total);
    return (total <= 2) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/timing_axis_counter.sv
// One raster axis: wrapping position counter with registered active and sync flags
// that describe the count shown in the same cycle.
module timing_axis_counter
  import video_timing_pkg::*;
#(
  parameter int   ACTIVE = VGA_H_ACTIVE,
  parameter int   FP     = VGA_H_FP,
  parameter int   SYNC   = VGA_H_SYNC,
  parameter int   BP     = VGA_H_BP,
  parameter logic POL    = ACTIVE_LOW,
  localparam int  TOTAL  = ACTIVE + FP + SYNC + BP,
  localparam int  W      = axis_width(TOTAL)
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         advance,
  output logic [W-1:0] count,
  output logic         active,
  output logic         sync,
  output logic         wrap
);

  // One extra bit keeps the window bounds exact when a bound equals 2**W.
  localparam logic [W:0] LAST       = (W+1)'(TOTAL - 1);
  localparam logic [W:0] ACT_END    = (W+1)'(ACTIVE);
  localparam logic [W:0] SYNC_START = (W+1)'(ACTIVE + FP);
  localparam logic [W:0] SYNC_END   = (W+1)'(ACTIVE + FP + SYNC);

  logic [W-1:0] count_next;
  logic [W:0]   count_next_ext;

  assign wrap           = ({1'b0, count} == LAST);
  assign count_next     = wrap ? '0 : count + 1'b1;
  assign count_next_ext = {1'b0, count_next};

  always_ff @(posedge clk) begin
    if (srst) begin
      count  <= '0;
      active <= 1'b1;
      sync   <= ~POL;
    end else if (advance) begin
      count  <= count_next;
      active <= (count_next_ext < ACT_END);
      sync   <= ((count_next_ext >= SYNC_START) && (count_next_ext < SYNC_END)) ? POL : ~POL;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator with pixel clock-enable.
// Optional raster-compare interrupt enabled by defining VTG_LINE_IRQ_EN.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   H_ACTIVE  = VGA_H_ACTIVE,
  parameter int   H_FP      = VGA_H_FP,
  parameter int   H_SYNC    = VGA_H_SYNC,
  parameter int   H_BP      = VGA_H_BP,
  parameter int   V_ACTIVE  = VGA_V_ACTIVE,
  parameter int   V_FP      = VGA_V_FP,
  parameter int   V_SYNC    = VGA_V_SYNC,
  parameter int   V_BP      = VGA_V_BP,
  parameter logic HSYNC_POL = ACTIVE_LOW,
  parameter logic VSYNC_POL = ACTIVE_LOW,
  localparam int  H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int  V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int  HW        = axis_width(H_TOTAL),
  localparam int  VW        = axis_width(V_TOTAL)
) (
  input  logic          vga_clock,
  input  logic          reset,
  input  logic          pixel_ce,
  input  logic [VW-1:0] line_cmp,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          at_display_area,
  output logic          start_of_frame,
  output logic          end_of_line,
  output logic [15:0]   frame_count,
  output logic          line_irq
);

  logic h_active, h_wrap;
  logic v_active, v_wrap;
  logic sof_next, eol_next;

  timing_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HSYNC_POL)
  ) h_axis (
    .clk    (vga_clock),
    .srst   (reset),
    .advance(pixel_ce),
    .count  (hcount),
    .active (h_active),
    .sync   (hsync),
    .wrap   (h_wrap)
  );

  timing_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VSYNC_POL)
  ) v_axis (
    .clk    (vga_clock),
    .srst   (reset),
    .advance(pixel_ce & h_wrap),
    .count  (vcount),
    .active (v_active),
    .sync   (vsync),
    .wrap   (v_wrap)
  );

  assign at_display_area = h_active & v_active;

  // Strobes are decoded from the position the counters are about to enter.
  assign sof_next = pixel_ce & h_wrap & v_wrap;
  assign eol_next = pixel_ce & ({1'b0, hcount} == (HW+1)'(H_TOTAL - 2));

  always_ff @(posedge vga_clock) begin
    if (reset) begin
      start_of_frame <= 1'b0;
      end_of_line    <= 1'b0;
      frame_count    <= 16'd0;
    end else begin
      start_of_frame <= sof_next;
      end_of_line    <= eol_next;
      if (sof_next) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

`ifdef VTG_LINE_IRQ_EN
  logic [VW-1:0] v_next;
  logic          irq_next;

  assign v_next   = v_wrap ? '0 : vcount + 1'b1;
  assign irq_next = pixel_ce & h_wrap & (v_next == line_cmp)
                  & ({1'b0, line_cmp} < (VW+1)'(V_TOTAL));

  always_ff @(posedge vga_clock) begin
    if (reset) begin
      line_irq <= 1'b0;
    end else begin
      line_irq <= irq_next;
    end
  end
`else
  logic unused_line_cmp;
  assign unused_line_cmp = ^line_cmp;
  assign line_irq        = 1'b0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a default 640x480 instance and a tiny raster instance,
// both checked every cycle against a position model derived from the advance count.
module tb_video_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] h;
    logic [15:0] v;
    logic        hs;
    logic        vs;
    logic        de;
    logic        sof;
    logic        eol;
    logic        irq;
    logic [15:0] fc;
  } obs_t;

  int errors = 0;
  int checks = 0;

  // Instance A: default 640x480 timing
  logic        rst_a = 1'b1, ce_a = 1'b0;
  logic [9:0]  lc_a = 10'd100;
  logic [9:0]  hc_a, vc_a;
  logic        hs_a, vs_a, de_a, sof_a, eol_a, irq_a;
  logic [15:0] fc_a;

  video_timing_gen dut_a (
    .vga_clock(clk), .reset(rst_a), .pixel_ce(ce_a), .line_cmp(lc_a),
    .hcount(hc_a), .vcount(vc_a), .hsync(hs_a), .vsync(vs_a),
    .at_display_area(de_a), .start_of_frame(sof_a), .end_of_line(eol_a),
    .frame_count(fc_a), .line_irq(irq_a)
  );

  // Instance B: 24 x 11 raster, active-high hsync
  logic        rst_b = 1'b1, ce_b = 1'b0;
  logic [3:0]  lc_b = 4'd0;
  logic [4:0]  hc_b;
  logic [3:0]  vc_b;
  logic        hs_b, vs_b, de_b, sof_b, eol_b, irq_b;
  logic [15:0] fc_b;

  video_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0)
  ) dut_b (
    .vga_clock(clk), .reset(rst_b), .pixel_ce(ce_b), .line_cmp(lc_b),
    .hcount(hc_b), .vcount(vc_b), .hsync(hs_b), .vsync(vs_b),
    .at_display_area(de_b), .start_of_frame(sof_b), .end_of_line(eol_b),
    .frame_count(fc_b), .line_irq(irq_b)
  );

  obs_t act_a, act_b;
  assign act_a = {16'(hc_a), 16'(vc_a), hs_a, vs_a, de_a, sof_a, eol_a, irq_a, fc_a};
  assign act_b = {16'(hc_b), 16'(vc_b), hs_b, vs_b, de_b, sof_b, eol_b, irq_b, fc_b};

  // Model state: pixel advances since the last reset, and whether the last edge advanced.
  longint na = 0, nb = 0;
  bit     adv_a = 0, adv_b = 0;
  int     lcs_b = 0;
  int     cyc = 0;

  // Expected outputs from the raster position n = advances since reset.
  function automatic obs_t model(input int ha, hf, hsw, hb, va, vf, vsw, vb,
                                 input logic hp, vp, input longint n, input bit adv,
                                 input int lc);
    obs_t   m;
    int     ht, vt, h, v;
    longint ft;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    ft = longint'(ht) * vt;
    h  = int'(n % ht);
    v  = int'((n / ht) % vt);
    m.h   = 16'(h);
    m.v   = 16'(v);
    m.hs  = (h >= ha + hf && h < ha + hf + hsw) ? hp : ~hp;
    m.vs  = (v >= va + vf && v < va + vf + vsw) ? vp : ~vp;
    m.de  = (h < ha) && (v < va);
    m.sof = adv && (n % ft == 0);
    m.eol = adv && (h == ht - 1);
`ifdef VTG_LINE_IRQ_EN
    m.irq = adv && (h == 0) && (v == lc) && (lc < vt);
`else
    m.irq = 1'b0;
`endif
    m.fc  = 16'((n / ft) % 65536);
    return m;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_obs(input string p, input obs_t a, input obs_t e);
    check({p, ".hcount"}, 32'(a.h), 32'(e.h));
    check({p, ".vcount"}, 32'(a.v), 32'(e.v));
    check({p, ".hsync"}, 32'(a.hs), 32'(e.hs));
    check({p, ".vsync"}, 32'(a.vs), 32'(e.vs));
    check({p, ".at_display_area"}, 32'(a.de), 32'(e.de));
    check({p, ".start_of_frame"}, 32'(a.sof), 32'(e.sof));
    check({p, ".end_of_line"}, 32'(a.eol), 32'(e.eol));
    check({p, ".line_irq"}, 32'(a.irq), 32'(e.irq));
    check({p, ".frame_count"}, 32'(a.fc), 32'(e.fc));
  endtask

  // One clock: drive inputs on the falling edge, sample 1 ns after the rising edge.
  task automatic step(input bit ra, ca, rb, cb, input int lcb);
    @(negedge clk);
    rst_a = ra; ce_a = ca; rst_b = rb; ce_b = cb; lc_b = 4'(lcb);
    @(posedge clk);
    #1;
    cyc++;
    if (ra) begin na = 0; adv_a = 0; end
    else begin adv_a = ca; if (ca) na++; end
    if (rb) begin nb = 0; adv_b = 0; end
    else begin adv_b = cb; if (cb) nb++; end
    lcs_b = lcb;
    check_obs("A", act_a, model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, na, adv_a, 100));
    check_obs("B", act_b, model(16, 2, 3, 3, 6, 1, 2, 2, 1'b1, 1'b0, nb, adv_b, lcs_b));
  endtask

  int hs_low_a, hs_high_b, eol_a_last, eol_a_period, eol_b_last, eol_b_period;
  int sof_b_last, sof_b_period, irq_cnt, exp_irq;

  initial begin
    // Reset with pixel_ce high: reset must dominate.
    for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 0);

    // Free-running ce=1 up to A at (400,2); measure sync widths and periods.
    hs_low_a = 0; hs_high_b = 0;
    eol_a_last = -1; eol_a_period = 0; eol_b_last = -1; eol_b_period = 0;
    sof_b_last = -1; sof_b_period = 0;
    for (int i = 0; i < 2000; i++) begin
      step(0, 1, 0, 1, 15);
      if (na < 800 && hs_a == 1'b0) hs_low_a++;
      if (nb < 24 && hs_b == 1'b1) hs_high_b++;
      if (eol_a) begin if (eol_a_last >= 0) eol_a_period = cyc - eol_a_last; eol_a_last = cyc; end
      if (eol_b) begin if (eol_b_last >= 0) eol_b_period = cyc - eol_b_last; eol_b_last = cyc; end
      if (sof_b) begin if (sof_b_last >= 0) sof_b_period = cyc - sof_b_last; sof_b_last = cyc; end
    end
    check("A.hsync_width", 32'(hs_low_a), 32'd96);
    check("A.line_period", 32'(eol_a_period), 32'd800);
    check("B.hsync_width", 32'(hs_high_b), 32'd3);
    check("B.line_period", 32'(eol_b_period), 32'd24);
    check("B.frame_period", 32'(sof_b_period), 32'd264);
    check("A.pos_before_reset", {6'd0, vc_a, 6'd0, hc_a}, {16'd2, 16'd400});

    // Mid-frame reset of A; the step's model check covers (0,0) and quiet strobes.
    step(1, 1, 0, 1, 15);
    check("A.reset_sof", 32'(sof_a), 32'd0);

    // ce 1-in-4 on B: frame period stretches fourfold.
    step(0, 0, 1, 0, 15);
    sof_b_last = -1; sof_b_period = 0;
    for (int i = 0; i < 3 * 264 * 4 + 8; i++) begin
      step(0, (i % 4) == 0, 0, (i % 4) == 0, 15);
      if (sof_b) begin if (sof_b_last >= 0) sof_b_period = cyc - sof_b_last; sof_b_last = cyc; end
    end
    check("B.frame_period_ce4", 32'(sof_b_period), 32'd1056);

    // Raster compare: in-range line fires once per frame, out-of-range never.
    step(0, 1, 1, 1, 3);
    irq_cnt = 0;
    for (int i = 0; i < 2 * 264; i++) begin
      step(0, 1, 0, 1, 3);
      if (irq_b) irq_cnt++;
    end
`ifdef VTG_LINE_IRQ_EN
    exp_irq = 2;
`else
    exp_irq = 0;
`endif
    check("B.irq_count_line3", 32'(irq_cnt), 32'(exp_irq));
    irq_cnt = 0;
    for (int i = 0; i < 2 * 264; i++) begin
      step(0, 1, 0, 1, 12);
      if (irq_b) irq_cnt++;
    end
    check("B.irq_count_line12", 32'(irq_cnt), 32'd0);

    // Random ce, random compare line, occasional resets.
    for (int i = 0; i < 15000; i++) begin
      step($urandom_range(0, 1999) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 799) == 0, $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
